fpu_arbiter: RTL

Shares a single FPU execution unit between `NUM_REQ` requesters (issue-stage lanes, DMA post-processing and so on) using round-robin arbitration. Each requester has a valid/ready request channel and a valid/ready response channel. The block sits between the requesters and the FPU's `f_*` handshake ports and keeps at most one operation outstanding. It also rejects illegal opcodes locally, so the FPU's sticky error output is never set by a requester mistake.

---
 rtl/fpu_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU among NUM_REQ requesters, one operation outstanding.
// Optional watchdog/drain behaviour is enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_vld,
  output logic [NUM_REQ-1:0]    req_rdy,
  input  logic [4*NUM_REQ-1:0]  req_ope,
  input  logic [32*NUM_REQ-1:0] req_in1,
  input  logic [32*NUM_REQ-1:0] req_in2,
  output logic [NUM_REQ-1:0]    rsp_vld,
  input  logic [NUM_REQ-1:0]    rsp_rdy,
  output logic [31:0]           rsp_data,
  output logic [2:0]            rsp_err,
  output logic [3:0]            f_ope_data,
  output logic [31:0]           f_in1_data,
  output logic [31:0]           f_in2_data,
  output logic                  f_in_vld,
  input  logic                  f_in_rdy,
  input  logic [31:0]           f_out_data,
  input  logic                  f_out_vld,
  output logic                  f_out_rdy,
  input  logic [2:0]            f_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("fpu_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
`ifdef FPU_ARB_TIMEOUT_EN
    , S_DRAIN
`endif
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [3:0]         r_ope;
  logic [31:0]        r_in1;
  logic [31:0]        r_in2;
  logic [31:0]        r_rsp_data;
  logic [2:0]         r_rsp_err;
  logic               w_gnt_any;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [3:0]         w_sel_ope;
  logic               w_legal;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   r_cnt;
  logic               r_drain;
  logic               w_to;
  assign w_to = (r_cnt == CNT_W'(TIMEOUT - 1));
`endif

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_any && req_vld[wrap_idx(r_ptr, k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = wrap_idx(r_ptr, k);
      end
    end
  end

  assign w_sel_ope = req_ope[4*w_gnt_idx +: 4];
  assign w_legal   = (w_sel_ope >= 4'd1) && (w_sel_ope <= 4'd11);

  always_comb begin
    w_state_nxt = r_state;
    req_rdy     = '0;
    rsp_vld     = '0;
    f_in_vld    = 1'b0;
    f_out_rdy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_any) begin
          // Gated by rstn so no handshake completes while reset is held.
          req_rdy[w_gnt_idx] = rstn;
          w_state_nxt        = w_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        f_in_vld = 1'b1;
        if (f_in_rdy) w_state_nxt = S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
        else if (w_to) w_state_nxt = S_RESP;
`endif
      end
      S_WAIT: begin
        f_out_rdy = 1'b1;
        if (f_out_vld) w_state_nxt = S_RESP;
`ifdef FPU_ARB_TIMEOUT_EN
        else if (w_to) w_state_nxt = S_RESP;
`endif
      end
      S_RESP: begin
        rsp_vld[r_owner] = 1'b1;
        if (rsp_rdy[r_owner]) begin
`ifdef FPU_ARB_TIMEOUT_EN
          w_state_nxt = r_drain ? S_DRAIN : S_IDLE;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef FPU_ARB_TIMEOUT_EN
      S_DRAIN: begin
        // A result abandoned by the watchdog is swallowed here.
        f_out_rdy = 1'b1;
        if (f_out_vld) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_ope      <= '0;
      r_in1      <= '0;
      r_in2      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_drain    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
`ifdef FPU_ARB_TIMEOUT_EN
          r_cnt   <= '0;
          r_drain <= 1'b0;
`endif
          if (w_gnt_any) begin
            r_owner <= w_gnt_idx;
            r_ope   <= w_sel_ope;
            r_in1   <= req_in1[32*w_gnt_idx +: 32];
            r_in2   <= req_in2[32*w_gnt_idx +: 32];
            if (!w_legal) begin
              r_rsp_data <= '0;
              r_rsp_err  <= 3'b001;
            end
          end
        end
        S_ISSUE: begin
`ifdef FPU_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 1'b1;
          if (!f_in_rdy && w_to) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 3'b100;
          end
`endif
        end
        S_WAIT: begin
`ifdef FPU_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 1'b1;
`endif
          if (f_out_vld) begin
            r_rsp_data <= f_out_data;
            r_rsp_err  <= f_err;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else if (w_to) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 3'b100;
            r_drain    <= 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_rdy[r_owner]) r_ptr <= wrap_idx(r_owner, 1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign f_ope_data = r_ope;
  assign f_in1_data = r_in1;
  assign f_in2_data = r_in2;

endmodule
